// File: rtl/apb_pkg.sv
// apb_pkg
// Shared APB definitions used by both the APB master bridge and the APB memory slave.
// Contents:
//   APB_ADDR_W  - default APB address width
//   APB_DATA_W  - default APB data width
//   apb_state_e - 2-bit APB transfer phase (IDLE / SETUP / ACCESS)
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer
// Saturating wait-state counter for the APB watchdog. It counts enabled cycles
// since the last clear. 'expired' is high while the count equals LIMIT-1. That
// marks the LIMIT-th consecutive enabled cycle, because the current cycle is
// not counted until its closing edge.
// Ports:
//   PCLK    in  clock
//   PRESETn in  asynchronous active-low reset (count -> 0)
//   clear   in  synchronous clear, wins over enable
//   enable  in  count this cycle
//   expired out current cycle is the LIMIT-th enabled cycle (or later)
module apb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The count saturates at MAX_CNT so it cannot wrap back to a non-expired value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != MAX_CNT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == MAX_CNT);

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Converts a valid/ready command stream into APB SETUP/ACCESS transfers, with one
// transfer outstanding at a time. It returns one registered response per command.
// A watchdog aborts a transfer whose slave holds PREADY low for TIMEOUT ACCESS
// cycles. TIMEOUT=0 removes the watchdog.
// Ports:
//   PCLK, PRESETn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (cmd_ready is combinational)
//   cmd_write, cmd_addr, cmd_wdata command payload
//   rsp_valid/rsp_ready            response handshake (registered slot)
//   rsp_rdata, rsp_err             read data (0 for writes/aborts), abort flag
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA  registered APB request outputs
//   PRDATA, PREADY                 APB completion inputs
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic cmd_fire;
  logic wd_expired;

  // A command is only taken when the response slot is free or draining this cycle.
  assign cmd_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;

  generate
    if (TIMEOUT > 0) begin : g_watchdog
      apb_wait_timer #(
        .LIMIT(TIMEOUT)
      ) u_wait_timer (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .clear  (cmd_fire),
        .enable ((state_q == ACCESS) && !PREADY),
        .expired(wd_expired)
      );
    end else begin : g_no_watchdog
      assign wd_expired = 1'b0;
    end
  endgenerate

  // State register plus all registered APB/response outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic. PREADY wins over the watchdog on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || wd_expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The address, direction and write data registers only load on
  // acceptance, so they hold their last values between transfers.
  always_comb begin
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = 1'b0;
        end else if (wd_expired) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Directed test of apb_master_bridge (TIMEOUT=4). A transaction-level model tracks
// the outstanding transfer as an age counter plus a response slot. It is checked
// against the DUT on every falling edge. Hand-computed literal checks pin the
// model at the key points of each scenario.
module tb_apb_master_bridge;

  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b1;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  apb_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Transaction-level model: 'age' counts cycles since acceptance (1 = setup phase,
  // 2 and up = access phase), and 'waits' counts access cycles that saw PREADY low.
  typedef struct packed {
    logic        busy;
    logic [31:0] age;
    logic [31:0] waits;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
  } model_t;

  model_t m;

  function automatic model_t stepModel(input model_t s, input logic cv, input logic cw,
                                       input logic [31:0] ca, input logic [31:0] cd,
                                       input logic rr, input logic pr, input logic [31:0] prd);
    model_t n = s;
    logic accept;
    accept = !s.busy && (!s.rsp_valid || rr) && cv;
    if (s.rsp_valid && rr) n.rsp_valid = 1'b0;
    if (s.busy) begin
      n.age = s.age + 1;
      if (s.age >= 2) begin
        if (pr) begin
          n.busy = 1'b0; n.rsp_valid = 1'b1; n.rsp_err = 1'b0;
          n.rsp_rdata = s.write ? 32'h0 : prd;
        end else begin
          n.waits = s.waits + 1;
          if (TO > 0 && n.waits >= TO) begin
            n.busy = 1'b0; n.rsp_valid = 1'b1; n.rsp_err = 1'b1; n.rsp_rdata = 32'h0;
          end
        end
      end
    end else if (accept) begin
      n.busy = 1'b1; n.age = 1; n.waits = 0;
      n.write = cw; n.addr = ca; n.wdata = cd;
    end
    return n;
  endfunction

  // The model advances on the same edges as the DUT and is cleared asynchronously by reset.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) m <= '0;
    else m <= stepModel(m, cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PRDATA);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge PCLK) begin
    if (chk_en) begin
      checkOutput("m_psel",      PSEL,      m.busy);
      checkOutput("m_penable",   PENABLE,   m.busy && (m.age >= 2));
      checkOutput("m_pwrite",    PWRITE,    m.write);
      checkOutput("m_paddr",     PADDR,     m.addr);
      checkOutput("m_pwdata",    PWDATA,    m.wdata);
      checkOutput("m_rsp_valid", rsp_valid, m.rsp_valid);
      checkOutput("m_rsp_rdata", rsp_rdata, m.rsp_rdata);
      checkOutput("m_rsp_err",   rsp_err,   m.rsp_err);
      checkOutput("m_cmd_ready", cmd_ready, !m.busy && (!m.rsp_valid || rsp_ready));
    end
  end

  // Present one command and hold it until the bridge takes it, within a cycle budget.
  // On return the time is just after the accepting edge, which starts the setup cycle.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit done = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge PCLK);
      if (cmd_ready) done = 1;
      @(posedge PCLK); #1;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL handshake_timeout: got no cmd_ready expected accept of addr 0x%0h", a);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    // Reset and idle state.
    @(posedge PCLK); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    @(negedge PCLK);
    checkOutput("rst_psel", PSEL, 0);
    checkOutput("rst_penable", PENABLE, 0);
    checkOutput("rst_paddr", PADDR, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);

    // Zero-wait write.
    PREADY = 1'b1;
    @(posedge PCLK); #1;
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge PCLK);
    checkOutput("wr_setup_psel", PSEL, 1);
    checkOutput("wr_setup_penable", PENABLE, 0);
    checkOutput("wr_setup_paddr", PADDR, 32'h10);
    checkOutput("wr_setup_pwrite", PWRITE, 1);
    checkOutput("wr_setup_pwdata", PWDATA, 32'hDEADBEEF);
    @(negedge PCLK);
    checkOutput("wr_access_penable", PENABLE, 1);
    @(negedge PCLK);
    checkOutput("wr_rsp_valid", rsp_valid, 1);
    checkOutput("wr_rsp_err", rsp_err, 0);
    checkOutput("wr_rsp_rdata", rsp_rdata, 0);
    checkOutput("wr_done_psel", PSEL, 0);

    // Read with 3 wait states.
    PREADY = 1'b0;
    @(posedge PCLK); #1;
    applyStimulus(1'b0, 32'h10, 32'h0);
    @(negedge PCLK);
    checkOutput("rd_setup_penable", PENABLE, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge PCLK); #1;
      if (i == 3) begin PREADY = 1'b1; PRDATA = 32'hDEADBEEF; end
      @(negedge PCLK);
      checkOutput("rd_wait_penable", PENABLE, 1);
      checkOutput("rd_wait_paddr", PADDR, 32'h10);
    end
    @(posedge PCLK); #1;
    PREADY = 1'b0; PRDATA = 32'h0;
    @(negedge PCLK);
    checkOutput("rd_rsp_valid", rsp_valid, 1);
    checkOutput("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    checkOutput("rd_rsp_err", rsp_err, 0);
    checkOutput("rd_done_psel", PSEL, 0);

    // Watchdog abort: PREADY stuck low.
    @(posedge PCLK); #1;
    applyStimulus(1'b1, 32'h20, 32'h12345678);
    @(negedge PCLK);
    for (int i = 0; i < TO; i++) begin
      @(posedge PCLK); #1;
      @(negedge PCLK);
      checkOutput("to_access_penable", PENABLE, 1);
    end
    @(posedge PCLK); #1;
    @(negedge PCLK);
    checkOutput("to_psel", PSEL, 0);
    checkOutput("to_penable", PENABLE, 0);
    checkOutput("to_rsp_valid", rsp_valid, 1);
    checkOutput("to_rsp_err", rsp_err, 1);
    checkOutput("to_rsp_rdata", rsp_rdata, 0);

    // A normal read after the abort.
    PREADY = 1'b1; PRDATA = 32'hA5A55A5A;
    @(posedge PCLK); #1;
    applyStimulus(1'b0, 32'h24, 32'h0);
    repeat (3) @(negedge PCLK);
    checkOutput("post_to_rsp_err", rsp_err, 0);
    checkOutput("post_to_rsp_rdata", rsp_rdata, 32'hA5A55A5A);

    // Response backpressure with a second command waiting.
    PRDATA = 32'h0BADF00D;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h30, 32'h0);
    repeat (3) @(negedge PCLK);
    checkOutput("bp_rsp_valid", rsp_valid, 1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h34; cmd_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1;
      @(negedge PCLK);
      checkOutput("bp_cmd_ready", cmd_ready, 0);
      checkOutput("bp_psel", PSEL, 0);
      checkOutput("bp_rsp_rdata", rsp_rdata, 32'h0BADF00D);
    end
    @(posedge PCLK); #1;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    checkOutput("bp_drain_cmd_ready", cmd_ready, 1);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    checkOutput("bp2_psel", PSEL, 1);
    checkOutput("bp2_paddr", PADDR, 32'h34);
    checkOutput("bp2_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge PCLK);
    checkOutput("bp2_rsp_valid_done", rsp_valid, 1);
    checkOutput("bp2_rsp_rdata", rsp_rdata, 0);

    // Reset during ACCESS.
    PREADY = 1'b0;
    @(posedge PCLK); #1;
    applyStimulus(1'b1, 32'h40, 32'h11112222);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    checkOutput("mr_penable", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    checkOutput("mr_async_psel", PSEL, 0);
    checkOutput("mr_async_penable", PENABLE, 0);
    checkOutput("mr_async_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge PCLK);
    #3 PRESETn = 1'b1;
    PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      checkOutput("mr_after_rsp_valid", rsp_valid, 0);
      checkOutput("mr_after_cmd_ready", cmd_ready, 1);
    end

    // Normal write after reset.
    @(posedge PCLK); #1;
    applyStimulus(1'b1, 32'h50, 32'h55AA55AA);
    repeat (3) @(negedge PCLK);
    checkOutput("final_rsp_valid", rsp_valid, 1);
    checkOutput("final_pwdata", PWDATA, 32'h55AA55AA);
    repeat (2) @(posedge PCLK);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
